// File: rtl/axis_video_frame_rx.sv
// AXI4-Stream video sink: accepts beats under rx_enable backpressure, tracks pixel
// coordinates from SOF/EOL markers and emits a registered pixel write port with framing checks.
module axis_video_frame_rx #(
  parameter int IMAGE_WIDTH    = 960,
  parameter int IMAGE_HEIGHT   = 540,
  parameter int PIXEL_PER_CLK  = 1,
  parameter int BITS_PER_PIXEL = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rx_enable,
  input  logic [BITS_PER_PIXEL*PIXEL_PER_CLK-1:0]   s_axis_video_in_tdata,
  input  logic                                      s_axis_video_in_tvalid,
  input  logic                                      s_axis_video_in_tlast,
  input  logic                                      s_axis_video_in_tuser,
  output logic                                      s_axis_video_in_tready,
  output logic                                      pix_valid,
  output logic [$clog2(IMAGE_WIDTH)-1:0]            pix_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]           pix_y,
  output logic [BITS_PER_PIXEL*PIXEL_PER_CLK-1:0]   pix_data,
  output logic                                      frame_done,
  output logic [15:0]                               frame_count,
  output logic [3:0]                                err_pulse,
  output logic [3:0]                                err_sticky,
  input  logic                                      err_clear,
  output logic                                      dbg_state_o
);

  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam int DW = BITS_PER_PIXEL * PIXEL_PER_CLK;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - PIXEL_PER_CLK);
  localparam logic [XW-1:0] X_STEP = XW'(PIXEL_PER_CLK);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  // Handshake: a beat transfers on a rising edge where tvalid && tready; tready depends
  // only on rx_enable and rst, never on tvalid.
  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            pix_valid_q, pix_valid_d;
  logic [XW-1:0]   pix_x_q, pix_x_d;
  logic [YW-1:0]   pix_y_q, pix_y_d;
  logic [DW-1:0]   pix_data_q, pix_data_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [3:0]      err_pulse_q, err_pulse_d;
  logic [3:0]      err_sticky_q, err_sticky_d;

  logic            accept;
  logic            emit;
  logic            eval_line;
  logic [XW-1:0]   beat_x;
  logic [YW-1:0]   beat_y;

  assign s_axis_video_in_tready = rx_enable && !rst;
  assign accept = s_axis_video_in_tvalid && s_axis_video_in_tready;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_data_d    = pix_data_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_pulse_d   = '0;
    emit          = 1'b0;
    eval_line     = 1'b0;
    beat_x        = x_q;
    beat_y        = y_q;

    if (accept) begin
      case (state_q)
        WAIT_SOF: begin
          if (!s_axis_video_in_tuser) begin
            err_pulse_d[0] = 1'b1;
          end else begin
            emit      = 1'b1;
            eval_line = 1'b1;
            beat_x    = '0;
            beat_y    = '0;
            state_d   = ACTIVE;
          end
        end
        ACTIVE: begin
          // An SOF anywhere but the very first pixel restarts the frame at (0,0).
          if (s_axis_video_in_tuser && !(x_q == '0 && y_q == '0)) begin
            err_pulse_d[1] = 1'b1;
            emit           = 1'b1;
            beat_x         = '0;
            beat_y         = '0;
            x_d            = X_STEP;
            y_d            = '0;
          end else begin
            emit      = 1'b1;
            eval_line = 1'b1;
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end

    if (emit) begin
      pix_valid_d = 1'b1;
      pix_x_d     = beat_x;
      pix_y_d     = beat_y;
      pix_data_d  = s_axis_video_in_tdata;
    end

    if (eval_line) begin
      if (beat_x == X_LAST || s_axis_video_in_tlast) begin
        err_pulse_d[3] = (beat_x == X_LAST) && !s_axis_video_in_tlast;
        err_pulse_d[2] = (beat_x != X_LAST) && s_axis_video_in_tlast;
        x_d = '0;
        if (beat_y == Y_LAST) begin
          y_d           = '0;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = WAIT_SOF;
        end else begin
          y_d = beat_y + YW'(1);
        end
      end else begin
        x_d = beat_x + X_STEP;
      end
    end

    err_sticky_d = err_clear ? 4'b0000 : (err_sticky_q | err_pulse_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_SOF;
      x_q           <= '0;
      y_q           <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_pulse_q   <= '0;
      err_sticky_q  <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axis_video_frame_rx.sv
// Bench for axis_video_frame_rx: an 8x4 one-pixel-per-beat sink and an 8x2 four-pixel sink,
// checked beat by beat against a rule-level frame model.
`timescale 1ns/1ps
module tb_axis_video_frame_rx;
  localparam int EW = 166;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_enable = 1'b0, tlast = 1'b0, tuser = 1'b0, err_clear = 1'b0;
  logic va = 1'b0, vb = 1'b0;
  logic [127:0] td = '0;

  logic a_tready, a_pix_valid, a_frame_done, a_state;
  logic [2:0] a_pix_x;
  logic [1:0] a_pix_y;
  logic [31:0] a_pix_data;
  logic [15:0] a_frame_count;
  logic [3:0] a_err_pulse, a_err_sticky;

  logic b_tready, b_pix_valid, b_frame_done, b_state;
  logic [2:0] b_pix_x;
  logic [0:0] b_pix_y;
  logic [127:0] b_pix_data;
  logic [15:0] b_frame_count;
  logic [3:0] b_err_pulse, b_err_sticky;

  always #5 clk = ~clk;

  axis_video_frame_rx #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .PIXEL_PER_CLK(1), .BITS_PER_PIXEL(32)) dut_a (
    .clk(clk), .rst(rst), .rx_enable(rx_enable),
    .s_axis_video_in_tdata(td[31:0]), .s_axis_video_in_tvalid(va),
    .s_axis_video_in_tlast(tlast), .s_axis_video_in_tuser(tuser),
    .s_axis_video_in_tready(a_tready), .pix_valid(a_pix_valid), .pix_x(a_pix_x), .pix_y(a_pix_y),
    .pix_data(a_pix_data), .frame_done(a_frame_done), .frame_count(a_frame_count),
    .err_pulse(a_err_pulse), .err_sticky(a_err_sticky), .err_clear(err_clear), .dbg_state_o(a_state));

  axis_video_frame_rx #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .PIXEL_PER_CLK(4), .BITS_PER_PIXEL(32)) dut_b (
    .clk(clk), .rst(rst), .rx_enable(rx_enable),
    .s_axis_video_in_tdata(td), .s_axis_video_in_tvalid(vb),
    .s_axis_video_in_tlast(tlast), .s_axis_video_in_tuser(tuser),
    .s_axis_video_in_tready(b_tready), .pix_valid(b_pix_valid), .pix_x(b_pix_x), .pix_y(b_pix_y),
    .pix_data(b_pix_data), .frame_done(b_frame_done), .frame_count(b_frame_count),
    .err_pulse(b_err_pulse), .err_sticky(b_err_sticky), .err_clear(err_clear), .dbg_state_o(b_state));

  // Scoreboard and reference model state (index 0 = dut_a, 1 = dut_b)
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  string cur_test = "init";
  bit clr_req = 1'b0;
  int cyc = 0;
  int cnt_pix = 0, cnt_done = 0;
  int cnt_err[4];
  int mw[2] = '{8, 8};
  int mh[2] = '{4, 2};
  int mp[2] = '{1, 4};
  bit m_act[2];
  int m_x[2], m_y[2], m_fc[2], last_x[2], last_y[2];
  logic [3:0] m_sticky[2], m_prev_err[2];

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit pat_en();
    return (cyc % 4 == 0) || (cyc % 4 == 3);
  endfunction

  function automatic void clear_counts();
    cnt_pix = 0;
    cnt_done = 0;
    for (int k = 0; k < 4; k++) cnt_err[k] = 0;
  endfunction

  // Frame rules applied to one accepted beat; pushes the expected output record.
  task automatic model_beat(input int d, input logic [127:0] data, input bit last, input bit user);
    int w = mw[d];
    int h = mh[d];
    int p = mp[d];
    int bx = 0;
    int by = 0;
    bit val = 1'b0;
    bit done = 1'b0;
    bit eval = 1'b0;
    logic [3:0] err = 4'b0;
    logic [127:0] mask = (d == 0) ? 128'hFFFF_FFFF : ~128'h0;
    if (!m_act[d]) begin
      if (!user) err[0] = 1'b1;
      else begin
        val = 1'b1; eval = 1'b1; m_act[d] = 1'b1;
      end
    end else if (user && !(m_x[d] == 0 && m_y[d] == 0)) begin
      err[1] = 1'b1; val = 1'b1; m_x[d] = p; m_y[d] = 0;
    end else begin
      val = 1'b1; eval = 1'b1; bx = m_x[d]; by = m_y[d];
    end
    if (eval) begin
      if (bx == w - p || last) begin
        if (!last) err[3] = 1'b1;
        if (bx != w - p) err[2] = 1'b1;
        m_x[d] = 0;
        if (by == h - 1) begin
          m_y[d] = 0; done = 1'b1; m_fc[d] = (m_fc[d] + 1) % 65536; m_act[d] = 1'b0;
        end else m_y[d] = by + 1;
      end else m_x[d] = bx + p;
    end
    exp_q.push_back({err, val, done, 16'(m_fc[d]), 8'(by), 8'(bx), data & mask});
    m_prev_err[d] = err;
  endtask

  // One clock: drive at the falling edge, model at the rising edge, score the outputs just after.
  task automatic cycle(input int d, input bit v, input logic [127:0] data, input bit last,
                       input bit user, input bit en, output bit acc);
    logic [EW-1:0] e;
    bit o_valid, o_done, o_rdy;
    int o_x, o_y, ex, ey;
    logic [127:0] o_data;
    logic [15:0] o_fc;
    logic [3:0] o_err, o_sticky;
    @(negedge clk);
    va = v && (d == 0); vb = v && (d == 1);
    td = data; tlast = last; tuser = user; rx_enable = en;
    err_clear = clr_req; clr_req = 1'b0; cyc++;
    #1;
    o_rdy = (d == 0) ? a_tready : b_tready;
    checks++;
    if (o_rdy !== en) begin
      errors++; $display("FAIL %s tready got %b exp %b", cur_test, o_rdy, en);
    end
    @(posedge clk);
    acc = v && en;
    for (int k = 0; k < 2; k++) begin
      m_sticky[k] = err_clear ? 4'b0 : (m_sticky[k] | m_prev_err[k]);
      m_prev_err[k] = 4'b0;
    end
    if (acc) model_beat(d, data, last, user);
    #1;
    o_valid  = (d == 0) ? a_pix_valid : b_pix_valid;
    o_done   = (d == 0) ? a_frame_done : b_frame_done;
    o_x      = (d == 0) ? int'(a_pix_x) : int'(b_pix_x);
    o_y      = (d == 0) ? int'(a_pix_y) : int'(b_pix_y);
    o_data   = (d == 0) ? {96'b0, a_pix_data} : b_pix_data;
    o_fc     = (d == 0) ? a_frame_count : b_frame_count;
    o_err    = (d == 0) ? a_err_pulse : b_err_pulse;
    o_sticky = (d == 0) ? a_err_sticky : b_err_sticky;
    if (o_valid === 1'b1) cnt_pix++;
    if (o_done === 1'b1) cnt_done++;
    for (int k = 0; k < 4; k++) if (o_err[k] === 1'b1) cnt_err[k]++;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = {4'b0, 1'b0, 1'b0, 16'(m_fc[d]), 8'b0, 8'b0, 128'b0};
    ex = e[161] ? int'(e[135:128]) : last_x[d];
    ey = e[161] ? int'(e[143:136]) : last_y[d];
    checks += 7;
    if (o_valid !== e[161]) begin errors++; $display("FAIL %s pix_valid got %b exp %b", cur_test, o_valid, e[161]); end
    if (o_err !== e[165:162]) begin errors++; $display("FAIL %s err_pulse got %b exp %b", cur_test, o_err, e[165:162]); end
    if (o_done !== e[160]) begin errors++; $display("FAIL %s frame_done got %b exp %b", cur_test, o_done, e[160]); end
    if (o_fc !== e[159:144]) begin errors++; $display("FAIL %s frame_count got %0d exp %0d", cur_test, o_fc, e[159:144]); end
    if (o_x != ex) begin errors++; $display("FAIL %s pix_x got %0d exp %0d", cur_test, o_x, ex); end
    if (o_y != ey) begin errors++; $display("FAIL %s pix_y got %0d exp %0d", cur_test, o_y, ey); end
    if (o_sticky !== m_sticky[d]) begin errors++; $display("FAIL %s err_sticky got %b exp %b", cur_test, o_sticky, m_sticky[d]); end
    if (e[161]) begin
      checks++;
      if (o_data !== e[127:0]) begin errors++; $display("FAIL %s pix_data got %h exp %h", cur_test, o_data, e[127:0]); end
      last_x[d] = ex; last_y[d] = ey;
    end
  endtask

  task automatic idle(input int d, input int n);
    bit acc;
    repeat (n) cycle(d, 1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic send_beat(input int d, input logic [127:0] data, input bit last, input bit user, input bit bp);
    bit acc = 1'b0;
    int n = 0;
    if (bp) repeat ($urandom_range(0, 2)) cycle(d, 1'b0, data, last, user, pat_en(), acc);
    acc = 1'b0;
    while (!acc && n < 40) begin
      cycle(d, 1'b1, data, last, user, bp ? pat_en() : 1'b1, acc);
      n++;
    end
    checks++;
    if (!acc) begin errors++; $display("FAIL %s beat_accept timeout after %0d cycles", cur_test, n); end
  endtask

  task automatic send_frame(input int d, input bit bp);
    int n = (mw[d] / mp[d]) * mh[d];
    for (int i = 0; i < n; i++) send_beat(d, rnd(), m_x[d] == mw[d] - mp[d], i == 0, bp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    va = 1'b0; vb = 1'b0; tuser = 1'b0; tlast = 1'b0; rx_enable = 1'b1; err_clear = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if ({a_tready, a_pix_valid, a_frame_done, a_err_pulse, a_err_sticky, a_frame_count} !== '0) begin
      errors++; $display("FAIL %s reset_ctrl_a got %b exp 0", cur_test,
        {a_tready, a_pix_valid, a_frame_done, a_err_pulse, a_err_sticky, a_frame_count});
    end
    if ({a_pix_x, a_pix_y, a_pix_data} !== '0) begin
      errors++; $display("FAIL %s reset_pix_a got %h exp 0", cur_test, {a_pix_x, a_pix_y, a_pix_data});
    end
    if ({b_tready, b_pix_valid, b_frame_done, b_err_pulse, b_err_sticky, b_frame_count} !== '0) begin
      errors++; $display("FAIL %s reset_ctrl_b got %b exp 0", cur_test,
        {b_tready, b_pix_valid, b_frame_done, b_err_pulse, b_err_sticky, b_frame_count});
    end
    if ({b_pix_x, b_pix_y, b_pix_data} !== '0) begin
      errors++; $display("FAIL %s reset_pix_b got %h exp 0", cur_test, {b_pix_x, b_pix_y, b_pix_data});
    end
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_x[k] = 0; m_y[k] = 0; m_fc[k] = 0;
      m_sticky[k] = 4'b0; m_prev_err[k] = 4'b0; last_x[k] = 0; last_y[k] = 0;
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    do_reset();
    idle(0, 2);
    idle(1, 2);
  endtask

  task automatic test_frame();
    cur_test = "frame_8x4";
    clear_counts();
    send_frame(0, 1'b0);
    idle(0, 2);
    checks += 4;
    if (cnt_pix != 32) begin errors++; $display("FAIL %s beat_count got %0d exp 32", cur_test, cnt_pix); end
    if (cnt_done != 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", cur_test, cnt_done); end
    if (a_frame_count !== 16'd1) begin errors++; $display("FAIL %s frame_count got %0d exp 1", cur_test, a_frame_count); end
    if (a_err_sticky !== 4'b0) begin errors++; $display("FAIL %s err_sticky got %b exp 0", cur_test, a_err_sticky); end
  endtask

  task automatic test_backpressure();
    cur_test = "backpressure";
    clear_counts();
    send_frame(0, 1'b1);
    idle(0, 2);
    checks += 3;
    if (cnt_pix != 32) begin errors++; $display("FAIL %s beat_count got %0d exp 32", cur_test, cnt_pix); end
    if (cnt_done != 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", cur_test, cnt_done); end
    if (a_frame_count !== 16'd2) begin errors++; $display("FAIL %s frame_count got %0d exp 2", cur_test, a_frame_count); end
  endtask

  task automatic test_ppc4();
    cur_test = "ppc4_8x2";
    clear_counts();
    send_frame(1, 1'b0);
    idle(1, 2);
    checks += 3;
    if (cnt_pix != 4) begin errors++; $display("FAIL %s beat_count got %0d exp 4", cur_test, cnt_pix); end
    if (cnt_done != 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", cur_test, cnt_done); end
    if (b_frame_count !== 16'd1) begin errors++; $display("FAIL %s frame_count got %0d exp 1", cur_test, b_frame_count); end
  endtask

  // Line 1 ends early at x=5 (error cleared in the same cycle it is reported); line 2 lacks tlast.
  task automatic test_eol_errors();
    cur_test = "eol_errors";
    clear_counts();
    for (int y = 0; y < 4; y++) begin
      for (int i = 0; i < ((y == 1) ? 6 : 8); i++) begin
        send_beat(0, rnd(), (y == 1) ? (i == 5) : ((y == 2) ? 1'b0 : (i == 7)), (y == 0 && i == 0), 1'b0);
        if (y == 1 && i == 5) clr_req = 1'b1;
      end
    end
    idle(0, 3);
    checks += 4;
    if (cnt_err[2] != 1) begin errors++; $display("FAIL %s eol_early_count got %0d exp 1", cur_test, cnt_err[2]); end
    if (cnt_err[3] != 1) begin errors++; $display("FAIL %s eol_late_count got %0d exp 1", cur_test, cnt_err[3]); end
    if (a_err_sticky !== 4'b1000) begin errors++; $display("FAIL %s err_sticky got %b exp 1000", cur_test, a_err_sticky); end
    if (a_frame_count !== 16'd3) begin errors++; $display("FAIL %s frame_count got %0d exp 3", cur_test, a_frame_count); end
  endtask

  task automatic test_sof_errors();
    int n = 0;
    cur_test = "sof_errors";
    do_reset();
    clear_counts();
    send_beat(0, rnd(), 1'b0, 1'b0, 1'b0);
    send_beat(0, rnd(), 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (cnt_pix != 0) begin errors++; $display("FAIL %s pix_before_sof got %0d exp 0", cur_test, cnt_pix); end
    if (cnt_err[0] != 2) begin errors++; $display("FAIL %s sof_missing_count got %0d exp 2", cur_test, cnt_err[0]); end
    for (int i = 0; i < 11; i++) send_beat(0, rnd(), i == 7, i == 0, 1'b0);
    send_beat(0, rnd(), 1'b0, 1'b1, 1'b0);
    while (m_act[0] && n < 64) begin
      send_beat(0, rnd(), m_x[0] == 7, 1'b0, 1'b0);
      n++;
    end
    idle(0, 3);
    checks += 4;
    if (cnt_err[1] != 1) begin errors++; $display("FAIL %s sof_early_count got %0d exp 1", cur_test, cnt_err[1]); end
    if (n != 31) begin errors++; $display("FAIL %s beats_after_restart got %0d exp 31", cur_test, n); end
    if (a_frame_count !== 16'd1) begin errors++; $display("FAIL %s frame_count got %0d exp 1", cur_test, a_frame_count); end
    if (a_err_sticky !== 4'b0011) begin errors++; $display("FAIL %s err_sticky got %b exp 0011", cur_test, a_err_sticky); end
  endtask

  task automatic test_reset_mid();
    cur_test = "reset_mid";
    for (int i = 0; i < 20; i++) send_beat(0, rnd(), m_x[0] == 7, i == 0, 1'b0);
    do_reset();
    clear_counts();
    send_frame(0, 1'b0);
    idle(0, 2);
    checks += 3;
    if (cnt_pix != 32) begin errors++; $display("FAIL %s beat_count got %0d exp 32", cur_test, cnt_pix); end
    if (a_frame_count !== 16'd1) begin errors++; $display("FAIL %s frame_count got %0d exp 1", cur_test, a_frame_count); end
    if (a_err_sticky !== 4'b0) begin errors++; $display("FAIL %s err_sticky got %b exp 0", cur_test, a_err_sticky); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) cnt_err[k] = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_frame();
    test_backpressure();
    test_ppc4();
    test_eol_errors();
    test_sof_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
